// File: rtl/run_sequencer.sv
// run_sequencer
//   Upstream controller for the 4-bit counting FSM. Accepts a job of N runs
//   over a valid/ready handshake, pulses go once per run, waits for done_sig
//   after each run and inserts a GAP-cycle idle gap between runs. Reports
//   progress (runs_done), job end (complete), and a sticky timeout error.
//
// Handshake: a job is accepted on a rising clk edge where start_valid=1 and
//   start_ready=1 (start_ready is high only in IDLE). start_runs is sampled on
//   that edge; start_valid may stay high afterwards without effect until the
//   sequencer is back in IDLE.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_valid     job request valid
//   start_ready     job can be accepted (IDLE)
//   start_runs      number of runs, sampled on accept
//   abort           cancel the current job (ignored in IDLE)
//   go              one-cycle run trigger to the counting FSM
//   done_sig        run finished, only counted in WAIT
//   busy            any state other than IDLE
//   runs_done       runs completed in current/last job
//   complete        one-cycle pulse on normal or timeout job end
//   timeout_err     sticky, cleared on next accepted start
//   job_cycles      busy-cycle count of the job (only with the macro below)
//   dbg_state       current FSM state encoding
//
// Optional feature: define RUN_SEQ_CYCLE_COUNT_EN to add job_cycles[15:0].
module run_sequencer #(
  parameter int COUNT_W = 8,
  parameter int TIMEOUT = 32,
  parameter int GAP     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [COUNT_W-1:0] start_runs,
  input  logic               abort,
  output logic               go,
  input  logic               done_sig,
  output logic               busy,
  output logic [COUNT_W-1:0] runs_done,
  output logic               complete,
  output logic               timeout_err,
`ifdef RUN_SEQ_CYCLE_COUNT_EN
  output logic [15:0]        job_cycles,
`endif
  output logic [2:0]         dbg_state
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [COUNT_W-1:0] RUN_ONE = COUNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_GAP    = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t             state;
  logic [COUNT_W-1:0] target;
  logic [TW-1:0]      timer;
  logic [GW-1:0]      gap_cnt;
  logic [COUNT_W-1:0] runs_next;

  assign runs_next = runs_done + RUN_ONE;

  // Outputs decode the state register only, so no input reaches an output
  // combinationally.
  assign start_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign go          = (state == S_ISSUE);
  assign complete    = (state == S_FINISH);
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      target      <= '0;
      timer       <= '0;
      gap_cnt     <= '0;
      runs_done   <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            target      <= start_runs;
            runs_done   <= '0;
            timeout_err <= 1'b0;
            state       <= (start_runs == '0) ? S_FINISH : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            timer <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // abort beats a coincident done_sig: the run is not counted.
          if (abort) begin
            state <= S_IDLE;
          end else if (done_sig) begin
            runs_done <= runs_next;
            if (runs_next == target) begin
              state <= S_FINISH;
            end else begin
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_FINISH;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_GAP: begin
          // Gives the counting FSM time to return to its idle state.
          if (abort) begin
            state <= S_IDLE;
          end else if (gap_cnt == GW'(GAP - 1)) begin
            state <= S_ISSUE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

`ifdef RUN_SEQ_CYCLE_COUNT_EN
  // Counts every busy cycle of the job, saturating; holds once back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      job_cycles <= '0;
    end else if (state == S_IDLE) begin
      if (start_valid) job_cycles <= '0;
    end else if (job_cycles != 16'hFFFF) begin
      job_cycles <= job_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;

  localparam int COUNT_W = 8;
  localparam int TIMEOUT = 32;
  localparam int GAP     = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               start_valid = 1'b0;
  logic               start_ready;
  logic [COUNT_W-1:0] start_runs = '0;
  logic               abort = 1'b0;
  logic               go;
  logic               done_sig = 1'b0;
  logic               busy;
  logic [COUNT_W-1:0] runs_done;
  logic               complete;
  logic               timeout_err;
  logic [2:0]         dbg_state;
`ifdef RUN_SEQ_CYCLE_COUNT_EN
  logic [15:0]        job_cycles;
`endif

  run_sequencer #(.COUNT_W(COUNT_W), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_runs(start_runs), .abort(abort),
    .go(go), .done_sig(done_sig), .busy(busy),
    .runs_done(runs_done), .complete(complete), .timeout_err(timeout_err),
`ifdef RUN_SEQ_CYCLE_COUNT_EN
    .job_cycles(job_cycles),
`endif
    .dbg_state(dbg_state)
  );

  // Cycle n is the period after the n-th rising edge; sampled on negedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [31:0] exp_q[$];     // expected go cycles
  logic [31:0] exp_rd_q[$];  // expected runs_done seen at each go
  int act_go[$];
  int act_rd[$];
  int act_cmp[$];

  always @(negedge clk) begin
    if (go) begin
      act_go.push_back(cyc);
      act_rd.push_back(int'(runs_done));
    end
    if (complete) act_cmp.push_back(cyc);
  end

  // ---------------- counting FSM model ----------------
  // Answers each go with a one-cycle done_sig d_cur cycles later; d_cur=0
  // means it never answers. hold_done forces done_sig high permanently.
  int   d_cur = 1;
  logic hold_done = 1'b0;
  logic hold_start = 1'b0;
  int   pend_q[$];

  always @(negedge clk) begin
    logic hit;
    hit = 1'b0;
    if (go && d_cur != 0) pend_q.push_back(cyc + d_cur);
    foreach (pend_q[i]) if (pend_q[i] == cyc) hit = 1'b1;
    while (pend_q.size() > 0 && pend_q[0] <= cyc) void'(pend_q.pop_front());
    done_sig = hold_done | hit;
  end

  // ---------------- driver tasks ----------------
  task automatic accept(input int runs, output int a);
    int budget;
    budget = 0;
    @(negedge clk);
    while (!start_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("accept_ready", start_ready, 1);
    act_go.delete(); act_rd.delete(); act_cmp.delete();
    start_runs  = COUNT_W'(runs);
    start_valid = 1'b1;
    a = cyc + 1;
    @(negedge clk);
    if (!hold_start) start_valid = 1'b0;
    check("accept_rd_clr", runs_done, 0);
    check("accept_to_clr", timeout_err, 0);
  endtask

  // Reference model: job timeline from plain arithmetic on the job rules.
  task automatic run_job(input int runs, input int d);
    int a, budget, g, last, exp_cmp, exp_rd, exp_to;
    d_cur = d;
    accept(runs, a);
    exp_q.delete(); exp_rd_q.delete();
    if (runs == 0) begin
      exp_cmp = a; exp_rd = 0; exp_to = 0;
    end else if (d == 0) begin
      exp_q.push_back(a); exp_rd_q.push_back(0);
      exp_cmp = a + TIMEOUT + 1; exp_rd = 0; exp_to = 1;
    end else begin
      g = a; last = a;
      for (int i = 0; i < runs; i++) begin
        exp_q.push_back(g); exp_rd_q.push_back(i);
        last = g;
        g = g + d + GAP + 1;
      end
      exp_cmp = last + d + 1; exp_rd = runs; exp_to = 0;
    end
    budget = 0;
    while (!complete && budget < 2000) begin
      check("busy_in_job", busy, 1);
      @(negedge clk);
      budget++;
    end
    check("complete_seen", complete, 1);
    start_valid = 1'b0;
    @(negedge clk);
    check("idle_after", busy, 0);
    check("ready_after", start_ready, 1);
    check("cmp_count", act_cmp.size(), 1);
    if (act_cmp.size() > 0) check("cmp_cycle", act_cmp[0] - a, exp_cmp - a);
    check("go_count", act_go.size(), exp_q.size());
    for (int i = 0; i < act_go.size() && i < exp_q.size(); i++) begin
      check("go_cycle", act_go[i] - a, exp_q[i] - a);
      check("rd_at_go", act_rd[i], exp_rd_q[i]);
    end
    check("runs_done", runs_done, exp_rd);
    check("timeout_err", timeout_err, exp_to);
`ifdef RUN_SEQ_CYCLE_COUNT_EN
    check("job_cycles", job_cycles, exp_cmp - a + 1);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, start_ready, 1);
    check({tag, "_go"}, go, 0);
    check({tag, "_cmp"}, complete, 0);
    check({tag, "_rd"}, runs_done, 0);
    check({tag, "_to"}, timeout_err, 0);
`ifdef RUN_SEQ_CYCLE_COUNT_EN
    check({tag, "_jc"}, job_cycles, 0);
`endif
  endtask

  task automatic wait_cycle(input int target);
    int budget;
    budget = 0;
    while (cyc < target && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    check("reach_cycle", cyc, target);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a, d, c_ab;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    run_job(3, 17);
    run_job(0, 5);
    run_job(2, 0);           // never answered: timeout
    run_job(1, TIMEOUT);     // answer on the last allowed WAIT cycle
    run_job(2, 1);

    // abort coincident with the second done_sig
    d = $urandom_range(2, 20);
    d_cur = d;
    accept(5, a);
    c_ab = a + d + GAP + 1 + d;
    wait_cycle(c_ab);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ready", start_ready, 1);
    check("abort_rd", runs_done, 1);
    check("abort_go", go, 0);
    repeat (30) @(negedge clk);
    check("abort_go_count", act_go.size(), 2);
    check("abort_cmp_count", act_cmp.size(), 0);
    check("abort_rd_hold", runs_done, 1);
`ifdef RUN_SEQ_CYCLE_COUNT_EN
    check("abort_jc", job_cycles, c_ab - a + 1);
`endif

    // done_sig and start_valid held high for a whole job
    hold_done = 1'b1;
    hold_start = 1'b1;
    run_job(3, 1);
    hold_done = 1'b0;
    hold_start = 1'b0;
    repeat (5) @(negedge clk);
    check("hold_no_reaccept", act_go.size(), 3);

    // reset in the middle of WAIT
    d_cur = 20;
    accept(4, a);
    wait_cycle(a + 5);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    rst = 1'b0;
    repeat (30) @(negedge clk);
    run_job(2, 4);

    // randomized jobs
    for (int k = 0; k < 14; k++) begin
      run_job($urandom_range(0, 4), $urandom_range(0, TIMEOUT));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
